// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART byte FIFO and its producer/consumer.
//   master : drives wr_valid/wr_data/wr_frame_err (receiver side),
//            rd_ready and clr_overrun (consumer side); observes status.
//   slave  : the FIFO; drives rd_valid/rd_data/rd_frame_err, count,
//            full, empty, overrun.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_frame_err;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_frame_err;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  overrun;
  logic                  clr_overrun;

  modport master (
    output wr_valid, wr_data, wr_frame_err, rd_ready, clr_overrun,
    input  rd_valid, rd_data, rd_frame_err, count, full, empty, overrun
  );

  modport slave (
    input  wr_valid, wr_data, wr_frame_err, rd_ready, clr_overrun,
    output rd_valid, rd_data, rd_frame_err, count, full, empty, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between a non-stallable UART receiver and a valid/ready consumer.
// Each entry carries the byte plus its framing-error bit; writes arriving
// while full (and not simultaneously popped) are dropped and latch a sticky
// overrun flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_fifo_if.slave (write pulse, read handshake, status)
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic full_c, empty_c, push_c, pop_c, drop_c;

  // Status decoded from registered count only.
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop_c  = ~empty_c & bus.rd_ready;
  assign push_c = bus.wr_valid & (~full_c | pop_c);
  assign drop_c = bus.wr_valid & ~push_c;

  // Next-state computation.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
    // A drop in the same cycle wins over the clear request.
    if (drop_c)               overrun_d = 1'b1;
    else if (bus.clr_overrun) overrun_d = 1'b0;
  end

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; contents are unreachable after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {bus.wr_frame_err, bus.wr_data};
  end

  assign {bus.rd_frame_err, bus.rd_data} = mem_q[rd_ptr_q];
  assign bus.rd_valid = ~empty_c;
  assign bus.count    = count_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for the single-entry
// handshake, hand-written sequences for full/overrun/reset corners, and a
// randomized push/pop run, all compared against a queue-based model.
module tb_uart_rx_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as {frame_err, data} plus overrun flag.
  logic [8:0] m_q [$];
  logic       m_ovr = 1'b0;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       we;
    logic       rr;
    logic       clr;
    logic [4:0] ecount;
    logic [8:0] ehead;
    logic       eovr;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_state(input string tag);
    check({tag, ".count"},    32'(bus.count), 32'(m_q.size()));
    check({tag, ".empty"},    32'(bus.empty), 32'(m_q.size() == 0));
    check({tag, ".full"},     32'(bus.full), 32'(m_q.size() == DEPTH));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_q.size() != 0));
    check({tag, ".overrun"},  32'(bus.overrun), 32'(m_ovr));
    if (m_q.size() != 0)
      check({tag, ".head"}, 32'({bus.rd_frame_err, bus.rd_data}), 32'(m_q[0]));
  endtask

  // One clock cycle of stimulus; model updated from its pre-edge state.
  task automatic step(input logic wv, input logic [7:0] wd, input logic we,
                      input logic rr, input logic clr);
    bit pop, push, drop;
    logic [8:0] tmp;
    bus.wr_valid     = wv;
    bus.wr_data      = wd;
    bus.wr_frame_err = we;
    bus.rd_ready     = rr;
    bus.clr_overrun  = clr;
    pop  = (m_q.size() != 0) && rr;
    push = wv && ((m_q.size() < DEPTH) || pop);
    drop = wv && !push;
    @(posedge clk);
    if (pop) tmp = m_q.pop_front();
    if (push) m_q.push_back({we, wd});
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    #1;
    bus.wr_valid    = 1'b0;
    bus.rd_ready    = 1'b0;
    bus.clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npush, npop, iter;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_frame_err = 1'b0;
    bus.rd_ready = 1'b0; bus.clr_overrun = 1'b0;

    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 5'd1, 9'h1A5, 1'b0};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 9'h1A5, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 9'h000, 1'b0};
    tbl[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 5'd1, 9'h03C, 1'b0};
    tbl[8] = '{1'b1, 8'h4D, 1'b0, 1'b1, 1'b0, 5'd1, 9'h04D, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 9'h000, 1'b0};

    repeat (2) @(posedge clk);
    do_reset();
    check_state("reset");

    // Single-entry handshake, hold while stalled, empty-pop ignored.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].we, tbl[i].rr, tbl[i].clr);
      check($sformatf("vec%0d.count", i), 32'(bus.count), 32'(tbl[i].ecount));
      check($sformatf("vec%0d.ovr", i), 32'(bus.overrun), 32'(tbl[i].eovr));
      if (tbl[i].ecount != 0)
        check($sformatf("vec%0d.head", i), 32'({bus.rd_frame_err, bus.rd_data}), 32'(tbl[i].ehead));
      check_state($sformatf("vec%0d", i));
    end

    // Fill to full, drop one, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("fill.full", 32'(bus.full), 32'd1);
    check("fill.count", 32'(bus.count), 32'd16);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    check("drop.overrun", 32'(bus.overrun), 32'd1);
    check("drop.count", 32'(bus.count), 32'd16);
    check_state("drop");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), 32'(bus.rd_data), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("drain.empty", 32'(bus.empty), 32'd1);
    check_state("drain");

    // Asynchronous reset mid-cycle with data stored and overrun set.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.empty", 32'(bus.empty), 32'd1);
    check("arst.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("arst.count", 32'(bus.count), 32'd0);
    check("arst.overrun", 32'(bus.overrun), 32'd0);
    m_q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("arst");

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check("fullpp.count", 32'(bus.count), 32'd16);
    check("fullpp.overrun", 32'(bus.overrun), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("ppdrain%0d", i), 32'(bus.rd_data), (i == 16) ? 32'h77 : 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check_state("ppdrain");

    // Random interleaving of 40 pushes and 40 pops across pointer wrap.
    npush = 0; npop = 0; iter = 0;
    while ((npush < 40 || npop < 40) && iter < 2000) begin
      logic wv, rr;
      rr = 1'($urandom_range(0, 1));
      wv = (npush < 40) && 1'($urandom_range(0, 1)) &&
           ((m_q.size() < DEPTH) || rr);
      if (rr && m_q.size() != 0) begin
        check($sformatf("rand.pop%0d", npop), 32'(bus.rd_data), 32'((npop * 3) % 256));
        npop++;
      end
      step(wv, 8'((npush * 3) % 256), 1'($urandom_range(0, 1)), rr, 1'b0);
      if (wv) npush++;
      if (32'(bus.count) > 16) check("rand.count_bound", 32'(bus.count), 32'd16);
      check_state("rand");
      iter++;
    end
    check("rand.done", 32'(npop), 32'd40);
    check("rand.overrun", 32'(bus.overrun), 32'd0);

    // Overrun set beats clear; clear alone works.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
    check("ovr.set", 32'(bus.overrun), 32'd1);
    step(1'b1, 8'hDE, 1'b0, 1'b0, 1'b1);
    check("ovr.clr_vs_set", 32'(bus.overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovr.clr", 32'(bus.overrun), 32'd0);
    check_state("ovr");

    // Reset with 5 entries stored; stale bytes must not reappear.
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("pre_rst.count", 32'(bus.count), 32'd5);
    do_reset();
    check("rst5.empty", 32'(bus.empty), 32'd1);
    check_state("rst5");
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    check("rst5.head", 32'({bus.rd_frame_err, bus.rd_data}), 32'h1EE);
    check("rst5.count", 32'(bus.count), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("rst5.empty2", 32'(bus.empty), 32'd1);
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
